stream_sum_accumulator: RTL and testbench
=========================================

// Module: stream_sum_accumulator
// PURPOSE
//  Parametrised sequential multi-operand adder: sums a stream of unsigned IN_WIDTH operands,
//  one per accepted beat, until a beat tagged last; presents the zero-extended sum,
//  operand count and overflow flag on a registered valid/ready output.
//  Generalises the fixed 16x8-bit chained-add-plus-output-register datapath to arbitrary
//  operand count, widths, wrap/saturate mode and flow control. Sits between operand producers and the REG/consumer stage.
// PARAMETERS
//  IN_WIDTH   8   operand width, unsigned, zero-extended to SUM_WIDTH
//  SUM_WIDTH  32  accumulator/result width (must be >= IN_WIDTH)
//  MAX_TERMS  16  max operands per sum; count_out width CW = $clog2(MAX_TERMS+1)
//  SATURATE   0   0: wrap modulo 2^SUM_WIDTH; 1: clamp at 2^SUM_WIDTH-1
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous, active-low reset
//  in_data    in   IN_WIDTH   operand
//  in_valid   in   1          operand present
//  in_last    in   1          final operand of current sum (qualified by in_valid)
//  in_ready   out  1          block can accept operand
//  sum_out    out  SUM_WIDTH  result, stable while out_valid
//  count_out  out  CW         operands summed into sum_out
//  ovf_out    out  1          1 if any add of this sum exceeded 2^SUM_WIDTH-1
//  trunc_out  out  1          1 if sum closed by MAX_TERMS, not by in_last
//  out_valid  out  1          result present
//  out_ready  in   1          consumer accepts result
// BEHAVIOUR
//  Reset (rst=0, async assert, sync release): state=ACC, acc=0, cnt=0, ovf=0; all outputs 0.
//  Beat accepted when in_valid & in_ready; result taken when out_valid & out_ready.
//  FSM, 2 states:
//   ACC : in_ready=1, out_valid=0. On accept: nxt = acc + zext(in_data) in SUM_WIDTH+1 bits;
//         carry -> ovf sticky; acc <= SATURATE&carry ? all-ones : nxt[SUM_WIDTH-1:0]; cnt++.
//         If in_last or cnt+1==MAX_TERMS: latch sum/count/ovf/trunc(=~in_last) to outputs,
//         go DONE. No accept -> hold.
//   DONE: in_ready=0, out_valid=1, outputs stable. On out_ready: clear acc/cnt/ovf, go ACC,
//         out_valid drops next cycle. in_valid ignored in DONE.
//  Latency: out_valid rises the cycle after the closing beat; single-operand sum legal (count=1).
//  Throughput: N operands -> N+1 cycles minimum (one bubble per result).
//  Saturated acc stays all-ones for remaining operands of that sum; ovf stays 1.
//  in_last with in_valid=0 has no effect. in_last on beat MAX_TERMS: trunc_out=0.
//  Zero operands (in_data=0) still counted. Reset mid-sum or mid-DONE discards all state.
//  sum_out/count_out/ovf_out/trunc_out hold last values after hand-off (don't-care while out_valid=0).
// TESTING
//  T1 defaults: 16 beats of 0xFF, last on 16th -> sum_out=0x00000FF0, count=16, ovf=0, trunc=0.
//  T2 defaults: beats 1..5, last on 5; out_ready held 0 for 4 cycles -> sum=15 stable, in_ready=0
//     throughout DONE; after out_ready=1, next sum starts from 0.
//  T3 SUM_WIDTH=10, SATURATE=0: 5x 0xFF last on 5th -> sum=0x0FB (1275 mod 1024), ovf=1.
//  T4 SUM_WIDTH=10, SATURATE=1: same stimulus -> sum=0x3FF, ovf=1, count=5.
//  T5 MAX_TERMS=4: 6 beats of 0x01, no last -> result sum=4, count=4, trunc=1; beats 5-6
//     begin new sum after hand-off.
//  T6 rst=0 asserted after 3 of 5 beats, released, then beats 7,8 last -> sum=15, count=2;
//     in_valid gaps between beats do not change result.

Source files
------------

// File: rtl/stream_sum_accumulator_if.sv
// Operand stream in, registered result stream out, for stream_sum_accumulator.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface stream_sum_accumulator_if #(
  parameter int IN_WIDTH  = 8,
  parameter int SUM_WIDTH = 32,
  parameter int MAX_TERMS = 16,
  localparam int CW       = $clog2(MAX_TERMS + 1)
);
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [SUM_WIDTH-1:0] sum_out;
  logic [CW-1:0]        count_out;
  logic                 ovf_out;
  logic                 trunc_out;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, sum_out, count_out, ovf_out, trunc_out, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, sum_out, count_out, ovf_out, trunc_out, out_valid
  );
endinterface

// File: rtl/stream_sum_accumulator.sv
// Sequential multi-operand adder: accumulates unsigned operands until a last beat or
// MAX_TERMS, then holds sum/count/overflow/truncation on a valid/ready output.
module stream_sum_accumulator #(
  parameter int IN_WIDTH  = 8,
  parameter int SUM_WIDTH = 32,
  parameter int MAX_TERMS = 16,
  parameter bit SATURATE  = 1'b0,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  stream_sum_accumulator_if.slave     io_bus
);

  typedef enum logic {ACC, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SUM_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf;
  logic [SUM_WIDTH-1:0] r_sum;
  logic [CW-1:0]        r_count;
  logic                 r_ovf_out;
  logic                 r_trunc;

  logic                 w_in_ready;
  logic                 w_accept;
  logic [SUM_WIDTH:0]   w_add;
  logic                 w_carry;
  logic [SUM_WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_close;

  // Carry-out of the widened add either wraps or clamps the accumulator.
  function automatic logic [SUM_WIDTH-1:0] sat_acc(input logic [SUM_WIDTH:0] a);
    if (SATURATE && a[SUM_WIDTH]) return {SUM_WIDTH{1'b1}};
    return a[SUM_WIDTH-1:0];
  endfunction

  assign w_in_ready = rst && (r_state == ACC);
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_add      = {1'b0, r_acc} + {{(SUM_WIDTH + 1 - IN_WIDTH){1'b0}}, io_bus.in_data};
  assign w_carry    = w_add[SUM_WIDTH];
  assign w_acc_nxt  = sat_acc(w_add);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_close    = w_accept && (io_bus.in_last || (w_cnt_inc == CW'(MAX_TERMS)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_close) w_state_nxt = DONE;
      DONE:    if (io_bus.out_ready) w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_count   <= '0;
      r_ovf_out <= 1'b0;
      r_trunc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ACC) begin
        if (w_accept) begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_inc;
          r_ovf <= r_ovf | w_carry;
        end
        if (w_close) begin
          r_sum     <= w_acc_nxt;
          r_count   <= w_cnt_inc;
          r_ovf_out <= r_ovf | w_carry;
          r_trunc   <= ~io_bus.in_last;
        end
      end else if (io_bus.out_ready) begin
        // Hand-off: the next sum starts clean; the result registers keep their values.
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = (r_state == DONE);
  assign io_bus.sum_out   = r_sum;
  assign io_bus.count_out = r_count;
  assign io_bus.ovf_out   = r_ovf_out;
  assign io_bus.trunc_out = r_trunc;

endmodule

// File: tb/tb_stream_sum_accumulator.sv
// Directed bench for stream_sum_accumulator: four parameterisations share one stimulus
// path selected by sel; a reference model pushes expected results into a scoreboard queue.
module tb_stream_sum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel = 2'd0;
  logic [7:0]  t_data = '0;
  logic        t_valid = 1'b0;
  logic        t_last = 1'b0;
  logic        t_oready = 1'b0;

  logic        o_ready, o_valid, o_ovf, o_trunc;
  logic [31:0] o_sum;
  logic [4:0]  o_cnt;

  stream_sum_accumulator_if #(.IN_WIDTH(8), .SUM_WIDTH(32), .MAX_TERMS(16)) if0 ();
  stream_sum_accumulator_if #(.IN_WIDTH(8), .SUM_WIDTH(10), .MAX_TERMS(16)) if1 ();
  stream_sum_accumulator_if #(.IN_WIDTH(8), .SUM_WIDTH(10), .MAX_TERMS(16)) if2 ();
  stream_sum_accumulator_if #(.IN_WIDTH(8), .SUM_WIDTH(32), .MAX_TERMS(4))  if3 ();

  stream_sum_accumulator #(.IN_WIDTH(8), .SUM_WIDTH(32), .MAX_TERMS(16), .SATURATE(1'b0))
    dut0 (.clk(clk), .rst(rst), .io_bus(if0));
  stream_sum_accumulator #(.IN_WIDTH(8), .SUM_WIDTH(10), .MAX_TERMS(16), .SATURATE(1'b0))
    dut1 (.clk(clk), .rst(rst), .io_bus(if1));
  stream_sum_accumulator #(.IN_WIDTH(8), .SUM_WIDTH(10), .MAX_TERMS(16), .SATURATE(1'b1))
    dut2 (.clk(clk), .rst(rst), .io_bus(if2));
  stream_sum_accumulator #(.IN_WIDTH(8), .SUM_WIDTH(32), .MAX_TERMS(4), .SATURATE(1'b0))
    dut3 (.clk(clk), .rst(rst), .io_bus(if3));

  assign if0.in_data = (sel == 2'd0) ? t_data : 8'd0;
  assign if1.in_data = (sel == 2'd1) ? t_data : 8'd0;
  assign if2.in_data = (sel == 2'd2) ? t_data : 8'd0;
  assign if3.in_data = (sel == 2'd3) ? t_data : 8'd0;
  assign if0.in_valid = (sel == 2'd0) && t_valid;
  assign if1.in_valid = (sel == 2'd1) && t_valid;
  assign if2.in_valid = (sel == 2'd2) && t_valid;
  assign if3.in_valid = (sel == 2'd3) && t_valid;
  assign if0.in_last = (sel == 2'd0) && t_last;
  assign if1.in_last = (sel == 2'd1) && t_last;
  assign if2.in_last = (sel == 2'd2) && t_last;
  assign if3.in_last = (sel == 2'd3) && t_last;
  assign if0.out_ready = (sel == 2'd0) && t_oready;
  assign if1.out_ready = (sel == 2'd1) && t_oready;
  assign if2.out_ready = (sel == 2'd2) && t_oready;
  assign if3.out_ready = (sel == 2'd3) && t_oready;

  always_comb begin
    o_ready = if0.in_ready;  o_valid = if0.out_valid; o_ovf = if0.ovf_out;
    o_trunc = if0.trunc_out; o_sum = if0.sum_out;     o_cnt = if0.count_out;
    case (sel)
      2'd1: begin
        o_ready = if1.in_ready;  o_valid = if1.out_valid; o_ovf = if1.ovf_out;
        o_trunc = if1.trunc_out; o_sum = 32'(if1.sum_out); o_cnt = if1.count_out;
      end
      2'd2: begin
        o_ready = if2.in_ready;  o_valid = if2.out_valid; o_ovf = if2.ovf_out;
        o_trunc = if2.trunc_out; o_sum = 32'(if2.sum_out); o_cnt = if2.count_out;
      end
      2'd3: begin
        o_ready = if3.in_ready;  o_valid = if3.out_valid; o_ovf = if3.ovf_out;
        o_trunc = if3.trunc_out; o_sum = if3.sum_out;     o_cnt = 5'(if3.count_out);
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] sum;
    logic [4:0]  cnt;
    logic        ovf;
    logic        trunc;
  } res_t;

  res_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [32:0] m_acc;
  int          m_cnt;
  logic        m_ovf;
  int          m_sw;
  bit          m_sat;
  int          m_maxt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic select(input logic [1:0] s, input int sw, input bit sat, input int maxt);
    sel    = s;
    m_sw   = sw;
    m_sat  = sat;
    m_maxt = maxt;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    logic [32:0] nxt, mask;
    logic        carry;
    res_t        r;
    int          g = 0;
    t_data = d; t_last = last; t_valid = 1'b1;
    while (!o_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) chk("send_ready_timeout", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;
    t_valid = 1'b0; t_last = 1'b0;
    mask  = (33'd1 << m_sw) - 33'd1;
    nxt   = m_acc + {25'd0, d};
    carry = nxt[m_sw];
    m_ovf = m_ovf | carry;
    m_acc = (m_sat && carry) ? mask : (nxt & mask);
    m_cnt++;
    if (last || m_cnt == m_maxt) begin
      r.sum = m_acc[31:0]; r.cnt = 5'(m_cnt); r.ovf = m_ovf; r.trunc = !last;
      sb.push_back(r);
      model_clear();
    end
  endtask

  task automatic drain(input string tag, input int hold);
    res_t e;
    int   g = 0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, {31'd0, o_valid}, 32'd1);
    while (!o_valid && g < 50) begin @(posedge clk); #1; g++; end
    chk({tag, "_sum"},   o_sum,             e.sum);
    chk({tag, "_count"}, {27'd0, o_cnt},    {27'd0, e.cnt});
    chk({tag, "_ovf"},   {31'd0, o_ovf},    {31'd0, e.ovf});
    chk({tag, "_trunc"}, {31'd0, o_trunc},  {31'd0, e.trunc});
    if (hold > 0) begin
      t_data = 8'd99; t_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk({tag, "_hold_ready"}, {31'd0, o_ready}, 32'd0);
        chk({tag, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, "_hold_sum"},   o_sum,            e.sum);
      end
      t_valid = 1'b0;
    end
    t_oready = 1'b1;
    @(posedge clk); #1;
    t_oready = 1'b0;
    chk({tag, "_handoff_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_handoff_ready"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    m_sw = 32; m_sat = 1'b0; m_maxt = 16;
    model_clear();
    idle(3);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_sum",   o_sum,            32'd0);
    chk("rst_count", {27'd0, o_cnt},   32'd0);
    chk("rst_ovf",   {31'd0, o_ovf},   32'd0);
    chk("rst_trunc", {31'd0, o_trunc}, 32'd0);
    rst = 1'b1;
    idle(1);
    chk("post_rst_ready", {31'd0, o_ready}, 32'd1);

    // T1: sixteen 0xFF beats, last on the sixteenth; a stray last without valid first.
    select(2'd0, 32, 1'b0, 16);
    t_last = 1'b1;
    idle(2);
    t_last = 1'b0;
    chk("last_no_valid", {31'd0, o_valid}, 32'd0);
    for (int i = 0; i < 16; i++) send(8'hFF, i == 15);
    chk("t1_expect_const", sb[0].sum, 32'h0000_0FF0);
    drain("t1", 0);

    // T2: 1..5 with a stalled consumer, then a fresh sum.
    for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
    drain("t2", 4);
    send(8'd3, 1'b0);
    send(8'd4, 1'b1);
    drain("t2_next", 0);

    // Single-operand sum and a zero operand.
    send(8'd0, 1'b1);
    drain("single_zero", 0);

    // T6: reset after three beats, then 7 and 8 with gaps.
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    rst = 1'b0;
    idle(2);
    chk("t6_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("t6_rst_sum",   o_sum,            32'd0);
    model_clear();
    rst = 1'b1;
    idle(1);
    send(8'd7, 1'b0);
    idle(3);
    send(8'd8, 1'b1);
    drain("t6", 0);

    // T3: 10-bit wrap.
    select(2'd1, 10, 1'b0, 16);
    for (int i = 0; i < 5; i++) send(8'hFF, i == 4);
    drain("t3", 0);

    // T4: 10-bit saturate.
    select(2'd2, 10, 1'b1, 16);
    for (int i = 0; i < 5; i++) send(8'hFF, i == 4);
    drain("t4", 0);

    // T5: MAX_TERMS=4 truncation, remaining beats start a new sum; last on beat 4 is not trunc.
    select(2'd3, 32, 1'b0, 4);
    for (int i = 0; i < 4; i++) send(8'h01, 1'b0);
    drain("t5", 0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b1);
    drain("t5_next", 0);
    for (int i = 0; i < 4; i++) send(8'h02, i == 3);
    drain("t5_last_at_max", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
